sub_bytes_pipe: RTL and testbench
=================================

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_BYTES, default 16, SHALL set the number of byte lanes substituted in parallel; legal values are 1..32.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port in_valid, input, 1, SHALL qualify in_data and in_inv.
REQ-006 Port in_ready, output, 1, SHALL indicate the block accepts a beat this cycle.
REQ-007 Port in_data, input, 8*NUM_BYTES, SHALL be the state bytes; lane i occupies bits [8i+7:8i].
REQ-008 Port in_inv, input, 1, SHALL select the mode: 0 = forward AES S-box, 1 = inverse AES S-box.
REQ-009 Port out_valid, output, 1, SHALL qualify out_data and out_inv.
REQ-010 Port out_ready, input, 1, SHALL be the downstream acceptance.
REQ-011 Port out_data, output, 8*NUM_BYTES, SHALL be the substituted bytes, with the lane order of in_data.
REQ-012 Port out_inv, output, 1, SHALL echo the mode used for the beat on out_data.

Function
REQ-013 Each lane SHALL map byte x to S(x) (FIPS-197 forward table) when the beat's mode is 0, or to S^-1(x) when it is 1; lanes are independent.
REQ-014 A beat SHALL be accepted when in_valid and in_ready are both high in the same cycle; it SHALL be delivered when out_valid and out_ready are both high.
REQ-015 The datapath SHALL have two register stages:
- S1 captures in_data and in_inv.
- S2 captures the table lookup of S1 together with the S1 mode.
REQ-016 Latency SHALL be exactly 2 cycles: a beat accepted at edge N SHALL appear with out_valid high after edge N+2 when out_ready is held high.
REQ-017 Throughput SHALL be one beat per cycle while out_ready is high; the block SHALL insert no bubbles.
REQ-018 Each stage SHALL advance when it is empty or when the stage after it advances, with out_ready as the final sink.
- in_ready = !s1_valid | s1_advance, combinational.
- in_ready SHALL have no combinational path from in_valid.
REQ-019 Stall: while out_valid=1 and out_ready=0, out_data and out_inv SHALL hold stable, and the block SHALL never drop or duplicate a beat.
REQ-020 Pipeline full: when both stages are valid and out_ready=0, in_ready SHALL be 0.
REQ-021 Simultaneous accept and deliver on a full pipeline SHALL shift both stages in the same cycle, leaving occupancy unchanged.
REQ-022 The mode SHALL be captured per beat, so consecutive beats MAY alternate mode with no penalty or flush.
REQ-023 When out_valid=0, out_data SHALL hold its last value; downstream logic SHALL not rely on it.
REQ-024 The forward and inverse tables SHALL be combinational per lane and replicated NUM_BYTES times, and SHALL contain no clocked ROM.

Reset
REQ-025 While rst=1:
- S1/S2 valid flags SHALL be cleared at the clock edge.
- out_valid=0, out_data=0 and out_inv=0 after that edge.
- in_ready SHALL be 0.
REQ-026 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats, and none SHALL emerge after reset.

Verification
REQ-028 Forward, NUM_BYTES=16: one beat with lane0=00, lane1=53, lane2=FF and the remaining lanes 01, in_inv=0, out_ready=1 -> 2 cycles later out_valid=1 with lane0=63, lane1=ED, lane2=16 and the remaining lanes 7C.
REQ-029 Inverse: the same lanes set to 63, ED, 16 with in_inv=1 -> out_data lanes 00, 53, FF and out_inv=1.
REQ-030 Alternating mode stream: 8 back-to-back beats with in_inv toggling every beat and out_ready=1 -> 8 consecutive out_valid cycles, each beat correct for its own mode, with no gaps.
REQ-031 Backpressure:
- Stimulus: out_ready=0 for 5 cycles while in_valid=1 continuously.
- Response: in_ready falls after 2 beats are accepted, and out_data stays stable.
- Then, with out_ready released, exactly the accepted beats emerge in order, with no loss.
REQ-032 Mid-stream reset: rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 and in_ready=0 during reset, no stale beat afterwards, and in_ready=1 on the next cycle.
REQ-033 Exhaustive: all 256 bytes in both modes, with random out_ready -> forward-then-inverse round trip equals the identity for every value and every lane.

Source files
------------

// File: rtl/sub_bytes_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_pipe
// Description : AES SubBytes / InvSubBytes over NUM_BYTES parallel byte lanes.
//               Two register stages (input capture, table-lookup result) with
//               valid/ready flow control on both sides. The mode travels with
//               each beat, so forward and inverse beats can interleave freely.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_pipe #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   out_inv
);

    localparam int c_DATA_W = 8 * NUM_BYTES;

    // Entry 0x00 sits in the most significant byte of each table, so entry x
    // lives at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
    localparam logic [2047:0] c_SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] f_sbox_fwd(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return c_SBOX_FWD[idx +: 8];
    endfunction

    function automatic logic [7:0] f_sbox_inv(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return c_SBOX_INV[idx +: 8];
    endfunction

    // Stage 1: raw input capture
    logic                r_s1_valid_q, w_s1_valid_d;
    logic [c_DATA_W-1:0] r_s1_data_q,  w_s1_data_d;
    logic                r_s1_inv_q,   w_s1_inv_d;
    // Stage 2: substituted bytes, drives the output port directly
    logic                r_s2_valid_q, w_s2_valid_d;
    logic [c_DATA_W-1:0] r_s2_data_q,  w_s2_data_d;
    logic                r_s2_inv_q,   w_s2_inv_d;

    logic                w_s2_ready;
    logic                w_in_ready;
    logic [c_DATA_W-1:0] w_sub;

    // Per-lane combinational table lookup, mode chosen by the beat in stage 1
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        assign w_sub[8*i +: 8] = r_s1_inv_q ? f_sbox_inv(r_s1_data_q[8*i +: 8])
                                            : f_sbox_fwd(r_s1_data_q[8*i +: 8]);
    end

    // Handshake and next-state logic for both stages
    always_comb begin
        // Stage 2 can take a new beat when empty or when its beat leaves now
        w_s2_ready = !r_s2_valid_q || out_ready;
        // Stage 1 advances exactly when stage 2 is ready; held off in reset
        w_in_ready = !rst && (!r_s1_valid_q || w_s2_ready);

        w_s1_valid_d = r_s1_valid_q;
        w_s1_data_d  = r_s1_data_q;
        w_s1_inv_d   = r_s1_inv_q;
        w_s2_valid_d = r_s2_valid_q;
        w_s2_data_d  = r_s2_data_q;
        w_s2_inv_d   = r_s2_inv_q;

        if (w_in_ready) begin
            w_s1_valid_d = in_valid;
            if (in_valid) begin
                w_s1_data_d = in_data;
                w_s1_inv_d  = in_inv;
            end
        end

        // Data only loads with a real beat, so it holds its last value when idle
        if (w_s2_ready) begin
            w_s2_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_s2_data_d = w_sub;
                w_s2_inv_d  = r_s1_inv_q;
            end
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q <= 1'b0;
            r_s1_data_q  <= '0;
            r_s1_inv_q   <= 1'b0;
            r_s2_valid_q <= 1'b0;
            r_s2_data_q  <= '0;
            r_s2_inv_q   <= 1'b0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_data_q  <= w_s1_data_d;
            r_s1_inv_q   <= w_s1_inv_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_s2_data_q  <= w_s2_data_d;
            r_s2_inv_q   <= w_s2_inv_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid_q;
    assign out_data  = r_s2_data_q;
    assign out_inv   = r_s2_inv_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_pipe
// Description : Directed self-checking bench for sub_bytes_pipe (16 lanes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_pipe;

    localparam int NB = 16;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_inv;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] src_mem [256];
    logic [W-1:0] mid_mem [256];
    logic [W-1:0] dst_mem [256];

    sub_bytes_pipe #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv)
    );

    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_inv !== 1'b0) $display("FAIL rst_out_inv: got %b want 0", out_inv); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else n_pass++;
        step();
    endtask

    task automatic test_forward();
        logic [W-1:0] d, e;
        d = {{(NB-3){8'h01}}, 8'hFF, 8'h53, 8'h00};
        e = {{(NB-3){8'h7C}}, 8'h16, 8'hED, 8'h63};
        in_valid = 1'b1; in_data = d; in_inv = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL fwd_in_ready: got %b want 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0; in_data = '0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL fwd_early_valid: got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL fwd_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== e) $display("FAIL fwd_out_data: got %h want %h", out_data, e); else n_pass++;
        n_checks++; if (out_inv !== 1'b0) $display("FAIL fwd_out_inv: got %b want 0", out_inv); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL fwd_dup_beat: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_inverse();
        logic [W-1:0] d, e;
        d = {{(NB-3){8'h7C}}, 8'h16, 8'hED, 8'h63};
        e = {{(NB-3){8'h01}}, 8'hFF, 8'h53, 8'h00};
        in_valid = 1'b1; in_data = d; in_inv = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL inv_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== e) $display("FAIL inv_out_data: got %h want %h", out_data, e); else n_pass++;
        n_checks++; if (out_inv !== 1'b1) $display("FAIL inv_out_inv: got %b want 1", out_inv); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL inv_dup_beat: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_alternating();
        logic [7:0] ins  [8];
        logic [7:0] exps [8];
        int n_out, first, last;
        ins  = '{8'h00, 8'h7C, 8'h10, 8'hB7, 8'h53, 8'h16, 8'h11, 8'hD2};
        exps = '{8'h63, 8'h01, 8'hCA, 8'h20, 8'hED, 8'hFF, 8'h82, 8'h7F};
        n_out = 0; first = -1; last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (out_valid) begin
                if (n_out < 8) begin
                    n_checks++; if (out_data !== {NB{exps[n_out]}}) $display("FAIL alt_data[%0d]: got %h want %h", n_out, out_data, {NB{exps[n_out]}}); else n_pass++;
                    n_checks++; if (out_inv !== n_out[0]) $display("FAIL alt_inv[%0d]: got %b want %b", n_out, out_inv, n_out[0]); else n_pass++;
                end else begin
                    n_checks++; $display("FAIL alt_extra_beat: got %0d beats want 8", n_out + 1);
                end
                if (first < 0) first = c;
                last = c;
                n_out++;
            end
            if (c < 8) begin
                in_valid = 1'b1; in_data = {NB{ins[c]}}; in_inv = c[0];
                #1;
                n_checks++; if (in_ready !== 1'b1) $display("FAIL alt_in_ready[%0d]: got %b want 1", c, in_ready); else n_pass++;
            end else begin
                in_valid = 1'b0; in_inv = 1'b0;
            end
            step();
        end
        n_checks++; if (n_out != 8) $display("FAIL alt_count: got %0d want 8", n_out); else n_pass++;
        n_checks++; if (last - first != 7) $display("FAIL alt_gaps: got span %0d want 7", last - first); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0]   bp_in  [4];
        logic [7:0]   bp_exp [2];
        logic [W-1:0] hold;
        int n_acc, n_out, unstable;
        logic have_hold;
        bp_in  = '{8'h01, 8'h10, 8'h20, 8'h40};
        bp_exp = '{8'h7C, 8'hCA};
        n_acc = 0; n_out = 0; unstable = 0; have_hold = 1'b0; hold = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = {NB{bp_in[n_acc]}}; in_inv = 1'b0;
            #1;
            if (out_valid) begin
                if (have_hold && out_data !== hold) unstable++;
                hold = out_data; have_hold = 1'b1;
            end
            if (in_ready) n_acc++;
            step();
        end
        n_checks++; if (n_acc != 2) $display("FAIL bp_accepted: got %0d want 2", n_acc); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (unstable != 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else n_pass++;
        n_checks++; if (out_data !== {NB{8'h7C}}) $display("FAIL bp_held_data: got %h want %h", out_data, {NB{8'h7C}}); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (n_out < 2) begin
                    n_checks++; if (out_data !== {NB{bp_exp[n_out]}}) $display("FAIL bp_drain[%0d]: got %h want %h", n_out, out_data, {NB{bp_exp[n_out]}}); else n_pass++;
                end else begin
                    n_checks++; $display("FAIL bp_extra_beat: got %0d beats want 2", n_out + 1);
                end
                n_out++;
            end
            step();
        end
        n_checks++; if (n_out != 2) $display("FAIL bp_drain_count: got %0d want 2", n_out); else n_pass++;
    endtask

    task automatic test_midstream_reset();
        int stale;
        stale = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
        in_data = {NB{8'h53}};
        step();
        in_data = {NB{8'hFF}};
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mrst_in_ready_pre: got %b want 0", in_ready); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL mrst_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mrst_in_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready_after: got %b want 1", in_ready); else n_pass++;
        step();
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stale++;
            step();
        end
        n_checks++; if (stale != 0) $display("FAIL mrst_stale_beats: got %0d want 0", stale); else n_pass++;
    endtask

    // Streams 256 beats through the DUT with random handshakes in one mode
    task automatic stream_pass(input logic mode);
        int n_in, n_out, cyc;
        logic [W-1:0] hold;
        logic hold_v;
        n_in = 0; n_out = 0; cyc = 0; hold = '0; hold_v = 1'b0;
        while (n_out < 256 && cyc < 4000) begin
            if (hold_v) begin
                n_checks++; if (out_data !== hold) $display("FAIL stall_hold m%0d: got %h want %h", mode, out_data, hold); else n_pass++;
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (n_in < 256) && ($urandom_range(0, 3) != 0);
            in_data   = (n_in < 256) ? (mode ? mid_mem[n_in] : src_mem[n_in]) : '0;
            in_inv    = mode;
            #1;
            hold_v = out_valid && !out_ready;
            hold   = out_data;
            if (out_valid && out_ready) begin
                n_checks++; if (out_inv !== mode) $display("FAIL stream_inv[%0d]: got %b want %b", n_out, out_inv, mode); else n_pass++;
                if (mode) dst_mem[n_out] = out_data;
                else      mid_mem[n_out] = out_data;
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++; if (n_out != 256) $display("FAIL stream_count m%0d: got %0d want 256", mode, n_out); else n_pass++;
    endtask

    task automatic test_exhaustive();
        logic [W-1:0] col0;
        for (int b = 0; b < 256; b++) begin
            for (int i = 0; i < NB; i++) begin
                src_mem[b][8*i +: 8] = 8'(b + 16 * i);
            end
        end
        stream_pass(1'b0);
        col0 = {8'h8C, 8'hE1, 8'h70, 8'hBA, 8'hE7, 8'hE0, 8'h60, 8'hCD,
                8'h51, 8'hD0, 8'h53, 8'h09, 8'h04, 8'hB7, 8'hCA, 8'h63};
        n_checks++; if (mid_mem[0] !== col0) $display("FAIL exh_fwd_col0: got %h want %h", mid_mem[0], col0); else n_pass++;
        stream_pass(1'b1);
        for (int b = 0; b < 256; b++) begin
            n_checks++; if (dst_mem[b] !== src_mem[b]) $display("FAIL round_trip[%0d]: got %h want %h", b, dst_mem[b], src_mem[b]); else n_pass++;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_alternating();
        test_backpressure();
        test_midstream_reset();
        test_exhaustive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
